tmr_voter_nbit: RTL and testbench
=================================

# tmr_voter_nbit

Parametrised N-bit triple-modular-redundancy voter with error injection, persistent-fault qualification and graceful degradation TMR → DUPLEX → FAIL. It sits between three redundant datapath replicas and downstream logic. It forwards a registered, voted word with a valid strobe, and reports per-channel fault flags and the current redundancy mode. A channel is declared faulty only after FAULT_THRESH consecutive dissenting samples, so transient upsets are masked without permanently degrading redundancy.

## Interface
- WIDTH, 8: data word width, ≥1
- FAULT_THRESH, 3: consecutive dissenting valid samples before a channel (or duplex pair) is declared faulty, ≥1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  sample strobe for data_a/b/c
- data_a, data_b, data_c  in  WIDTH  replica words
- err_ctrl_a, err_ctrl_b, err_ctrl_c  in  WIDTH  bitwise error injection; effective word = data_x ^ err_ctrl_x
- clear_fault  in  1  clears fault flags, counters and mode back to TMR
- out_valid  out  1  registered copy of in_valid
- data_out  out  WIDTH  voted or selected word
- tmr_error  out  1  uncorrectable or unresolved disagreement on this sample
- fault_flags  out  3  {c,b,a} sticky channel-fault flags
- mode  out  2  0 = TMR, 1 = DUPLEX, 2 = FAIL

## Operation
- Effective words: ea/eb/ec = data ^ err_ctrl. All decisions use effective words. Word comparison is full-width equality.
- When in_valid=0: out_valid=0, data_out/tmr_error hold, and counters, flags and mode hold.
- TMR mode, valid sample:
  - data_out = bitwise majority of ea, eb, ec.
  - Sole dissenter X (other two equal, X differs): cnt_X++; the other counters clear; tmr_error=0.
  - All equal: all counters clear; tmr_error=0.
  - Three-way disagreement (all pairwise different, WIDTH>1 only): tmr_error=1; counters hold.
  - cnt_X reaching FAULT_THRESH sets fault_flags[X] and moves to DUPLEX. Only one channel can dissent per sample.
- DUPLEX mode: the two healthy channels are compared.
  - Equal: data_out = lower-index healthy word; tmr_error=0; dup_cnt clears.
  - Unequal: data_out = lower-index healthy word; tmr_error=1; dup_cnt++.
  - dup_cnt reaching FAULT_THRESH → FAIL. Flags are unchanged; the faulty member cannot be identified.
- FAIL mode: data_out = last_good, the last data_out emitted with tmr_error=0 (reset value 0). tmr_error=1 on every valid sample. Exit only via reset or clear_fault.
- clear_fault (any mode): fault_flags=0, all counters=0, mode=TMR, last_good kept. It takes priority over detection on the same cycle; the sample is still voted and output under the pre-clear mode.
- reset: out_valid=0, data_out=0, tmr_error=0, fault_flags=0, mode=TMR, counters=0, last_good=0. It is effective mid-operation with no residual state.

## Timing
- All outputs are registered. A sample at edge n appears on data_out/out_valid/tmr_error after edge n+1, giving latency 1.
- The sample whose dissent reaches FAULT_THRESH is still voted under the old mode. The flag and mode change are visible in the same cycle as that sample's output. The new mode governs samples from the next valid sample onward.
- Counter width is $clog2(FAULT_THRESH+1). Counters saturate and never wrap.
- There is no backpressure; one sample is accepted per cycle.

## Structure
- Package tmr_pkg:
  - mode enum (MODE_TMR, MODE_DUPLEX, MODE_FAIL)
  - channel index constants CH_A=0, CH_B=1, CH_C=2
  - a helper function returning the lower-index healthy channel from fault_flags
- Sub-module tmr_dissent_counter (saturating consecutive counter with inc/clr/hit):
  - instantiated 3× for the channels
  - instantiated 1× for dup_cnt

## Test plan
All scenarios use WIDTH=8, FAULT_THRESH=3.
- Reset, then 4 valid samples with all words 8'hA5 → data_out=8'hA5, tmr_error=0, mode=0, fault_flags=000, out_valid one cycle after in_valid.
- err_ctrl_b=8'h01 for 2 valid samples, then 0 for one, then 8'h01 for 2 more → data_out=8'hA5 throughout, fault_flags=000 (counter cleared by the clean sample).
- err_ctrl_b=8'h01 for 3 consecutive valid samples → third output is 8'hA5 with fault_flags=010 and mode=1. The next sample with data_a=8'h3C, err_ctrl_c=8'h00 outputs 8'h3C.
- In DUPLEX (b faulty), ea=8'h5A, then err_ctrl_c=8'hFF for 3 samples → each outputs 8'h5A with tmr_error=1. The third shows mode=2. Subsequent samples output 8'h5A (last_good) with tmr_error=1 regardless of inputs.
- TMR with ea=8'h00, eb=8'h0F, ec=8'hF0 → data_out=8'h00, tmr_error=1, counters unchanged (verify with a following 2-sample b dissent not faulting).
- From FAIL, assert clear_fault → next cycle mode=0, fault_flags=000. Then assert reset mid-stream with in_valid=1 → next cycle all outputs 0.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared definitions for the N-bit TMR voter.
//   mode_t          redundancy mode reported on the voter's mode output
//   CH_A/CH_B/CH_C  channel indices, matching bit positions in fault_flags
//   lower_healthy   lowest-index channel whose fault flag is clear
//   upper_healthy   highest-index channel whose fault flag is clear
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_TMR    = 2'd0,
        MODE_DUPLEX = 2'd1,
        MODE_FAIL   = 2'd2
    } mode_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    function automatic logic [1:0] lower_healthy(input logic [2:0] flags);
        if (!flags[CH_A]) return CH_A;
        if (!flags[CH_B]) return CH_B;
        return CH_C;
    endfunction

    function automatic logic [1:0] upper_healthy(input logic [2:0] flags);
        if (!flags[CH_C]) return CH_C;
        if (!flags[CH_B]) return CH_B;
        return CH_A;
    endfunction

endpackage

// File: rtl/tmr_dissent_counter.sv
// Saturating consecutive-event counter used for fault qualification.
//   clk    clock
//   reset  synchronous active-high reset
//   inc    count one more consecutive event
//   clr    restart the run (wins over inc)
//   hit    combinational: this inc brings the run to THRESH
module tmr_dissent_counter #(
    parameter int THRESH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(THRESH + 1);
    localparam logic [CW-1:0] MAX = CW'(THRESH);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    // Saturate at THRESH so a long run can never wrap back below it.
    assign count_inc = (count == MAX) ? MAX : count + 1'b1;
    assign hit       = inc & (count_inc == MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/tmr_voter_nbit.sv
// Triple-modular-redundancy voter with error injection, persistent-fault
// qualification and graceful degradation TMR -> DUPLEX -> FAIL.
//   clk, reset                 clock, synchronous active-high reset
//   in_valid                   sample strobe
//   data_a/b/c                 replica words
//   err_ctrl_a/b/c             XOR error-injection masks
//   clear_fault                return to TMR, clear flags and counters
//   out_valid                  registered in_valid
//   data_out                   voted / selected word
//   tmr_error                  sample could not be resolved cleanly
//   fault_flags                {c,b,a} sticky channel-fault flags
//   mode                       0 TMR, 1 DUPLEX, 2 FAIL
//
// state       | meaning
// MODE_TMR    | bitwise majority of three, sole dissenters qualified
// MODE_DUPLEX | one channel flagged, remaining pair compared
// MODE_FAIL   | pair disagreed persistently, last good word replayed
module tmr_voter_nbit
    import tmr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FAULT_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] err_ctrl_a,
    input  logic [WIDTH-1:0] err_ctrl_b,
    input  logic [WIDTH-1:0] err_ctrl_c,
    input  logic             clear_fault,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             tmr_error,
    output logic [2:0]       fault_flags,
    output logic [1:0]       mode
);

    mode_t            mode_q, mode_nxt;
    logic [2:0]       flags_q, flags_nxt;
    logic [WIDTH-1:0] last_good;

    logic [WIDTH-1:0] ea, eb, ec, maj;
    logic             eq_ab, eq_ac, eq_bc;
    logic             three_way;
    logic [2:0]       dissent;

    logic [WIDTH-1:0] word_lo, word_hi;
    logic             pair_eq;

    logic             in_tmr, in_dup;
    logic [2:0]       inc_ch, clr_ch, hit_ch;
    logic             dup_inc, dup_clr, dup_hit;

    logic [WIDTH-1:0] data_nxt;
    logic             err_nxt;

    assign ea  = data_a ^ err_ctrl_a;
    assign eb  = data_b ^ err_ctrl_b;
    assign ec  = data_c ^ err_ctrl_c;
    assign maj = (ea & eb) | (ea & ec) | (eb & ec);

    assign eq_ab = (ea == eb);
    assign eq_ac = (ea == ec);
    assign eq_bc = (eb == ec);

    // A sole dissenter is the channel outside an agreeing pair.
    assign dissent[CH_A] = eq_bc & ~eq_ab;
    assign dissent[CH_B] = eq_ac & ~eq_ab;
    assign dissent[CH_C] = eq_ab & ~eq_ac;
    assign three_way     = ~eq_ab & ~eq_ac & ~eq_bc;

    always_comb begin
        word_lo = ec;
        case (lower_healthy(flags_q))
            CH_A:    word_lo = ea;
            CH_B:    word_lo = eb;
            default: word_lo = ec;
        endcase
    end

    always_comb begin
        word_hi = ea;
        case (upper_healthy(flags_q))
            CH_C:    word_hi = ec;
            CH_B:    word_hi = eb;
            default: word_hi = ea;
        endcase
    end

    assign pair_eq = (word_lo == word_hi);

    assign in_tmr = in_valid & (mode_q == MODE_TMR);
    assign in_dup = in_valid & (mode_q == MODE_DUPLEX);

    // clear_fault gates every increment so it always wins over detection.
    assign inc_ch  = dissent & {3{in_tmr & ~clear_fault}};
    assign clr_ch  = {3{clear_fault}} | ({3{in_tmr & ~three_way}} & ~dissent);
    assign dup_inc = in_dup & ~pair_eq & ~clear_fault;
    assign dup_clr = clear_fault | (in_dup & pair_eq);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        tmr_dissent_counter #(
            .THRESH(FAULT_THRESH)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (inc_ch[i]),
            .clr  (clr_ch[i]),
            .hit  (hit_ch[i])
        );
    end

    tmr_dissent_counter #(
        .THRESH(FAULT_THRESH)
    ) u_dup_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (dup_inc),
        .clr  (dup_clr),
        .hit  (dup_hit)
    );

    // The output word is always produced under the current (pre-transition) mode.
    always_comb begin
        data_nxt = maj;
        err_nxt  = 1'b0;
        case (mode_q)
            MODE_TMR: begin
                data_nxt = maj;
                err_nxt  = three_way;
            end
            MODE_DUPLEX: begin
                data_nxt = word_lo;
                err_nxt  = ~pair_eq;
            end
            default: begin
                data_nxt = last_good;
                err_nxt  = 1'b1;
            end
        endcase
    end

    always_comb begin
        mode_nxt  = mode_q;
        flags_nxt = flags_q;
        if (clear_fault) begin
            mode_nxt  = MODE_TMR;
            flags_nxt = '0;
        end else if (|hit_ch) begin
            flags_nxt = flags_q | hit_ch;
            mode_nxt  = MODE_DUPLEX;
        end else if (dup_hit) begin
            mode_nxt = MODE_FAIL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_TMR;
            flags_q   <= '0;
            last_good <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            tmr_error <= 1'b0;
        end else begin
            mode_q    <= mode_nxt;
            flags_q   <= flags_nxt;
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= data_nxt;
                tmr_error <= err_nxt;
                if (!err_nxt) begin
                    last_good <= data_nxt;
                end
            end
        end
    end

    assign fault_flags = flags_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_tmr_voter_nbit.sv
// Self-checking bench for tmr_voter_nbit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_tmr_voter_nbit;

    localparam int W = 8;
    localparam int T = 3;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] data_a, data_b, data_c;
    logic [W-1:0] err_ctrl_a, err_ctrl_b, err_ctrl_c;
    logic         clear_fault;
    logic         out_valid;
    logic [W-1:0] data_out;
    logic         tmr_error;
    logic [2:0]   fault_flags;
    logic [1:0]   mode;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    tmr_voter_nbit #(
        .WIDTH       (W),
        .FAULT_THRESH(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_a     (data_a),
        .data_b     (data_b),
        .data_c     (data_c),
        .err_ctrl_a (err_ctrl_a),
        .err_ctrl_b (err_ctrl_b),
        .err_ctrl_c (err_ctrl_c),
        .clear_fault(clear_fault),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .tmr_error  (tmr_error),
        .fault_flags(fault_flags),
        .mode       (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_err;
    logic [W-1:0] m_last;
    logic [2:0]   m_flags;
    int           m_mode;
    int           m_cnt [3];
    int           m_dup;

    always @(posedge clk) begin : model
        logic [W-1:0] e [3];
        int  diss, lo, hi, ones;
        logic three;
        if (reset) begin
            m_valid = 0; m_data = 0; m_err = 0; m_last = 0;
            m_flags = 0; m_mode = 0; m_dup = 0;
            for (int x = 0; x < 3; x++) m_cnt[x] = 0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                e[0] = data_a ^ err_ctrl_a;
                e[1] = data_b ^ err_ctrl_b;
                e[2] = data_c ^ err_ctrl_c;
                three = (e[0] != e[1]) && (e[0] != e[2]) && (e[1] != e[2]);
                diss = -1;
                for (int x = 0; x < 3; x++)
                    if (e[(x+1)%3] == e[(x+2)%3] && e[x] != e[(x+1)%3]) diss = x;
                if (m_mode == 0) begin
                    for (int i = 0; i < W; i++) begin
                        ones = int'(e[0][i]) + int'(e[1][i]) + int'(e[2][i]);
                        m_data[i] = (ones >= 2);
                    end
                    m_err = three;
                end else if (m_mode == 1) begin
                    lo = -1; hi = -1;
                    for (int x = 0; x < 3; x++)
                        if (!m_flags[x]) begin
                            if (lo < 0) lo = x; else hi = x;
                        end
                    m_data = e[lo];
                    m_err  = (e[lo] != e[hi]);
                end else begin
                    m_data = m_last;
                    m_err  = 1;
                end
                if (!m_err) m_last = m_data;
                if (!clear_fault) begin
                    if (m_mode == 0 && !three) begin
                        for (int x = 0; x < 3; x++)
                            m_cnt[x] = (x == diss) ? ((m_cnt[x] < T) ? m_cnt[x] + 1 : T) : 0;
                        if (diss >= 0 && m_cnt[diss] == T) begin
                            m_flags[diss] = 1'b1;
                            m_mode = 1;
                        end
                    end else if (m_mode == 1) begin
                        if (m_err) begin
                            m_dup = (m_dup < T) ? m_dup + 1 : T;
                            if (m_dup == T) m_mode = 2;
                        end else begin
                            m_dup = 0;
                        end
                    end
                end
            end
            if (clear_fault) begin
                m_flags = 0; m_mode = 0; m_dup = 0;
                for (int x = 0; x < 3; x++) m_cnt[x] = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_data_out", 32'(data_out), 32'(m_data));
            chk("m_tmr_error", 32'(tmr_error), 32'(m_err));
            chk("m_fault_flags", 32'(fault_flags), 32'(m_flags));
            chk("m_mode", 32'(mode), 32'(m_mode));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic v, input logic [W-1:0] a, b, c, xa, xb, xc,
                        input logic clr, input logic rst);
        @(negedge clk);
        in_valid = v; data_a = a; data_b = b; data_c = c;
        err_ctrl_a = xa; err_ctrl_b = xb; err_ctrl_c = xc;
        clear_fault = clr; reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [W-1:0] a, b, c, xa, xb, xc);
        tick(1'b1, a, b, c, xa, xb, xc, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] xbs [5];
        logic [W-1:0] base, wa, wb, wc, xa, xb, xc;
        int r, bad;
        logic v, clr, rst;

        reset = 1; in_valid = 0; clear_fault = 0;
        data_a = 0; data_b = 0; data_c = 0;
        err_ctrl_a = 0; err_ctrl_b = 0; err_ctrl_c = 0;

        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_en = 1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_tmr_error", 32'(tmr_error), 0);
        chk("rst_flags", 32'(fault_flags), 0);
        chk("rst_mode", 32'(mode), 0);

        for (int k = 0; k < 4; k++) begin
            samp(8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
            chk("clean_valid", 32'(out_valid), 1);
            chk("clean_data", 32'(data_out), 32'h A5);
            chk("clean_err", 32'(tmr_error), 0);
        end
        tick(0, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_hold", 32'(data_out), 32'h A5);

        // transient dissent broken by a clean sample
        xbs = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
        for (int k = 0; k < 5; k++) begin
            samp(8'hA5, 8'hA5, 8'hA5, 0, xbs[k], 0);
            chk("trans_data", 32'(data_out), 32'h A5);
            chk("trans_flags", 32'(fault_flags), 0);
        end
        samp(8'hA5, 8'hA5, 8'hA5, 0, 0, 0);

        // persistent b dissent
        for (int k = 0; k < 3; k++) begin
            samp(8'hA5, 8'hA5, 8'hA5, 0, 8'h01, 0);
            chk("bflt_data", 32'(data_out), 32'h A5);
            chk("bflt_flags", 32'(fault_flags), (k == 2) ? 3'b010 : 3'b000);
            chk("bflt_mode", 32'(mode), (k == 2) ? 1 : 0);
        end
        samp(8'h3C, 8'hA5, 8'hA5, 0, 0, 0);
        chk("dup_lower", 32'(data_out), 32'h 3C);

        samp(8'h5A, 8'h5A, 8'h5A, 0, 0, 0);
        chk("dup_eq_data", 32'(data_out), 32'h 5A);
        chk("dup_eq_err", 32'(tmr_error), 0);
        for (int k = 0; k < 3; k++) begin
            samp(8'h5A, 8'h5A, 8'h5A, 0, 0, 8'hFF);
            chk("dup_ne_data", 32'(data_out), 32'h 5A);
            chk("dup_ne_err", 32'(tmr_error), 1);
            chk("dup_ne_mode", 32'(mode), (k == 2) ? 2 : 1);
        end
        for (int k = 0; k < 3; k++) begin
            samp(W'($urandom), W'($urandom), W'($urandom), 0, 0, 0);
            chk("fail_data", 32'(data_out), 32'h 5A);
            chk("fail_err", 32'(tmr_error), 1);
        end

        tick(1, 8'h11, 8'h22, 8'h33, 0, 0, 0, 1, 0);
        chk("clr_data", 32'(data_out), 32'h 5A);
        chk("clr_mode", 32'(mode), 0);
        chk("clr_flags", 32'(fault_flags), 0);

        // three-way disagreement must hold (not clear) the b counter
        samp(8'h00, 8'h00, 8'h00, 0, 8'h01, 0);
        samp(8'h00, 8'h0F, 8'hF0, 0, 0, 0);
        chk("tw_data", 32'(data_out), 32'h 00);
        chk("tw_err", 32'(tmr_error), 1);
        samp(8'h00, 8'h00, 8'h00, 0, 8'h01, 0);
        chk("tw_hold_flags", 32'(fault_flags), 0);
        samp(8'h00, 8'h00, 8'h00, 0, 8'h01, 0);
        chk("tw_fault_flags", 32'(fault_flags), 3'b010);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr2_flags", 32'(fault_flags), 0);

        samp(8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
        tick(1, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0, 0, 1);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_data", 32'(data_out), 0);
        chk("mrst_err", 32'(tmr_error), 0);
        chk("mrst_mode", 32'(mode), 0);

        // randomized traffic
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) bad = $urandom_range(0, 2);
            base = W'($urandom);
            wa = base; wb = base; wc = base;
            xa = 0; xb = 0; xc = 0;
            r = $urandom_range(0, 99);
            if (r < 35) begin
                case (bad)
                    0: xa = W'($urandom_range(1, 255));
                    1: xb = W'($urandom_range(1, 255));
                    default: xc = W'($urandom_range(1, 255));
                endcase
            end else if (r < 45) begin
                wa = W'($urandom); wb = W'($urandom); wc = W'($urandom);
            end else if (r < 52) begin
                xb = W'($urandom_range(1, 255));
                xc = W'($urandom_range(1, 255));
            end
            v   = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick(v, wa, wb, wc, xa, xb, xc, clr, rst);
        end

        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
